fpga_cfg_chain_ctrl: RTL and testbench

- Sequencer that serially loads a configuration chain of fpga_dffer cells, which are D flip-flops with clock enable and asynchronous reset.
- Accepts configuration words over a valid/ready stream and shifts them into the chain one bit per cycle, LSB first.
- Drives exactly CHAIN_LEN chain enables per load, then holds the chain (enable low) and reports done.
- Sits between the configuration port and the fabric's configuration register chain.

---
 rtl/fpga_cfg_chain_ctrl.sv | 110 +++++++++++
 tb/tb_fpga_cfg_chain_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_chain_ctrl.sv
// Serial loader for a chain of fpga_dffer configuration cells: accepts words over
// valid/ready and shifts CHAIN_LEN bits into the chain LSB first, then holds it.
module fpga_cfg_chain_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic              cfg_e_o,
    output logic              cfg_d_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  bit_cnt_o
);

    // state | meaning
    // IDLE  | chain untouched, waiting for start
    // LOAD  | ready for the next configuration word, chain holds
    // SHIFT | one bit per cycle into the chain head, enable high
    // DONE  | CHAIN_LEN bits shifted, chain holds, done level high
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int IDX_W = $clog2(WORD_W + 1);

    state_t            state, state_nx;
    logic [WORD_W-1:0] shreg, shreg_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [IDX_W-1:0]  word_left, word_left_nx;
    logic              last_bit;
    logic              last_in_word;

    assign bit_cnt_o    = bit_cnt;
    assign last_bit     = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign last_in_word = (word_left == '0);

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        bit_cnt_nx   = bit_cnt;
        word_left_nx = word_left;
        if (abort_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state_nx   = LOAD;
                        bit_cnt_nx = '0;
                    end
                end
                LOAD: begin
                    // wready_o is high for the whole LOAD state, so valid alone completes the handshake
                    if (wvalid_i) begin
                        state_nx     = SHIFT;
                        shreg_nx     = wdata_i;
                        word_left_nx = IDX_W'(WORD_W - 1);
                    end
                end
                SHIFT: begin
                    shreg_nx     = shreg >> 1;
                    bit_cnt_nx   = bit_cnt + 1'b1;
                    word_left_nx = word_left - 1'b1;
                    if (last_bit)
                        state_nx = DONE;
                    else if (last_in_word)
                        state_nx = LOAD;
                end
                DONE: begin
                    if (start_i) begin
                        state_nx   = LOAD;
                        bit_cnt_nx = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered so the fabric enable is glitch-free.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            word_left <= '0;
            wready_o  <= 1'b0;
            cfg_e_o   <= 1'b0;
            cfg_d_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            bit_cnt   <= bit_cnt_nx;
            word_left <= word_left_nx;
            wready_o  <= (state_nx == LOAD);
            cfg_e_o   <= (state_nx == SHIFT);
            cfg_d_o   <= (state_nx == SHIFT) && shreg_nx[0];
            busy_o    <= (state_nx == LOAD) || (state_nx == SHIFT);
            done_o    <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_fpga_cfg_chain_ctrl.sv
// Bench for fpga_cfg_chain_ctrl: random configuration loads checked against a
// bit-stream model and a behavioural 12-cell fpga_dffer chain.
module tb_fpga_cfg_chain_ctrl;

    localparam int CL = 12;
    localparam int WW = 8;
    localparam int CW = $clog2(CL + 1);
    localparam int NW = (CL + WW - 1) / WW;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic          abort_i;
    logic [WW-1:0] wdata_i;
    logic          wvalid_i;
    logic          wready_o;
    logic          cfg_e_o;
    logic          cfg_d_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] bit_cnt_o;

    fpga_cfg_chain_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .wdata_i   (wdata_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .cfg_e_o   (cfg_e_o),
        .cfg_d_o   (cfg_d_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .bit_cnt_o (bit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fabric side: every enabled edge shifts cfg_d_o into cell 0; cells reset with the system.
    logic          seen[$];
    int            en_cyc[$];
    int            cyc = 0;
    logic [CL-1:0] chain;

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain <= '0;
        end else begin
            cyc <= cyc + 1;
            if (cfg_e_o) begin
                seen.push_back(cfg_d_o);
                en_cyc.push_back(cyc);
                chain <= {chain[CL-2:0], cfg_d_o};
            end
        end
    end

    logic [WW-1:0] words[NW];
    int            base;

    function automatic logic [63:0] exp_stream();
        logic [63:0] e = '0;
        for (int i = 0; i < CL; i++) e[i] = words[i / WW][i % WW];
        return e;
    endfunction

    function automatic logic [63:0] exp_chain();
        logic [63:0] s = exp_stream();
        logic [63:0] c = '0;
        for (int k = 0; k < CL; k++) c[k] = s[CL - 1 - k];
        return c;
    endfunction

    task automatic rand_words();
        for (int i = 0; i < NW; i++) words[i] = WW'($urandom);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!wready_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        if (!wready_o) chk("ready_timeout", 0, 1);
    endtask

    task automatic begin_load(input string nm);
        base = seen.size();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({nm, "_start_ready"}, wready_o, 1);
        chk({nm, "_start_cnt"}, bit_cnt_o, 0);
        chk({nm, "_start_done"}, done_o, 0);
        chk({nm, "_start_e"}, cfg_e_o, 0);
    endtask

    // gaps: cycles valid stays low while the controller sits in LOAD before words 1..NW-1
    task automatic feed(input string nm, input int gaps, input bit poke);
        for (int i = 0; i < NW; i++) begin
            wdata_i  = words[i];
            wvalid_i = (i == 0 || gaps == 0);
            wait_ready();
            if (!wvalid_i) begin
                repeat (gaps) begin
                    chk({nm, "_gap_e"}, cfg_e_o, 0);
                    chk({nm, "_gap_ready"}, wready_o, 1);
                    @(negedge clk_i);
                end
                wvalid_i = 1'b1;
            end
            @(negedge clk_i);
            if (i == 0 && poke) begin
                @(negedge clk_i);
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
                chk({nm, "_poke_busy"}, busy_o, 1);
            end
        end
        wvalid_i = 1'b0;
    endtask

    task automatic finish_load(input string nm, input int gaps);
        int            k = 0;
        int            n;
        logic [63:0]   got = '0;
        while (!done_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        n = seen.size() - base;
        for (int i = 0; i < n && i < 64; i++) got[i] = seen[base + i];
        chk({nm, "_done"}, done_o, 1);
        chk({nm, "_cnt"}, bit_cnt_o, CL);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_e_off"}, cfg_e_o, 0);
        chk({nm, "_n_enables"}, n, CL);
        chk({nm, "_stream"}, got, exp_stream());
        if (n > 0)
            chk({nm, "_span"}, en_cyc[base + n - 1] - en_cyc[base] + 1, CL + (NW - 1) * (1 + gaps));
        chk({nm, "_chain"}, {52'b0, chain}, exp_chain());
    endtask

    initial begin
        reset_i  = 1'b1;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        wvalid_i = 1'b0;
        wdata_i  = '0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", wready_o, 0);
        chk("rst_e", cfg_e_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", bit_cnt_o, 0);

        // reset landing in the middle of a shift
        rand_words();
        begin_load("t1");
        wdata_i  = words[0];
        wvalid_i = 1'b1;
        @(negedge clk_i);
        wvalid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("t1_pre_e", cfg_e_o, 1);
        #1 reset_i = 1'b1;
        #1;
        chk("t1_async_e", cfg_e_o, 0);
        chk("t1_async_ready", wready_o, 0);
        chk("t1_async_busy", busy_o, 0);
        chk("t1_async_done", done_o, 0);
        chk("t1_async_cnt", bit_cnt_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        // fixed words, valid held high
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        begin_load("t2");
        feed("t2", 0, 1'b0);
        finish_load("t2", 0);
        begin
            logic [63:0] g = '0;
            for (int i = 0; i < CL; i++) g[i] = seen[base + i];
            chk("t2_a5_3c_seq", g, 64'hCA5);
        end

        // chain must stay put while idle in DONE
        repeat (10) @(negedge clk_i);
        chk("t6_hold_chain", {52'b0, chain}, exp_chain());
        chk("t6_hold_enables", seen.size() - base, CL);

        // valid withheld for 5 cycles in LOAD
        rand_words();
        begin_load("t3");
        feed("t3", 5, 1'b0);
        finish_load("t3", 5);

        // abort after 5 bits of word 0
        rand_words();
        begin_load("t4");
        wdata_i  = words[0];
        wvalid_i = 1'b1;
        @(negedge clk_i);
        wvalid_i = 1'b0;
        begin
            int k = 0;
            while (bit_cnt_o != CW'(5) && k < 50) begin
                @(negedge clk_i);
                k++;
            end
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("t4_abort_e", cfg_e_o, 0);
        chk("t4_abort_ready", wready_o, 0);
        chk("t4_abort_busy", busy_o, 0);
        chk("t4_abort_done", done_o, 0);
        chk("t4_abort_cnt", bit_cnt_o, 5);
        repeat (2) @(negedge clk_i);
        chk("t4_idle_cnt", bit_cnt_o, 5);
        rand_words();
        begin_load("t4b");
        feed("t4b", 0, 1'b0);
        finish_load("t4b", 0);

        // start pulsed mid-shift is ignored; start in DONE restarts
        rand_words();
        begin_load("t5");
        feed("t5", 0, 1'b1);
        finish_load("t5", 0);
        rand_words();
        begin_load("t5b");
        feed("t5b", 0, 1'b0);
        finish_load("t5b", 0);

        // random loads
        for (int r = 0; r < 6; r++) begin
            int g = $urandom_range(0, 3);
            bit p = 1'($urandom_range(0, 1));
            rand_words();
            begin_load("rnd");
            feed("rnd", g, p);
            finish_load("rnd", g);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end

        repeat (10) @(negedge clk_i);
        chk("end_hold_chain", {52'b0, chain}, exp_chain());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
